// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/DM requester ports, memory bus and status of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one fixed-latency single-port memory
// Optional macro ARB_RR_EN: alternate the winner on ties instead of fixed DM priority.
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [3:0]    count;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          if_done_q;
  logic          dm_done_q;
  logic          busy_q;
  logic          owner_q;
  logic          dm_wins;

`ifdef ARB_RR_EN
  logic          last_owner;

  always_comb begin
    dm_wins = bus.dm_req;
    if (bus.dm_req && bus.if_req) dm_wins = ~last_owner;
  end
`else
  always_comb begin
    dm_wins = bus.dm_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
`ifdef ARB_RR_EN
      last_owner  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            owner_q    <= dm_wins;
            mem_addr_q <= dm_wins ? bus.dm_addr : bus.if_addr;
            mem_we_q   <= dm_wins & bus.dm_we;
            if (dm_wins) mem_wdata_q <= bus.dm_wdata;
            count      <= 4'(LAT - 1);
            mem_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ACCESS;
`ifdef ARB_RR_EN
            last_owner <= dm_wins;
`endif
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            // mem_rdata is only valid in this last access cycle
            if (!mem_we_q) begin
              if (owner_q) dm_rdata_q <= bus.mem_rdata;
              else         if_rdata_q <= bus.mem_rdata;
            end
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            dm_done_q <= owner_q;
            if_done_q <= ~owner_q;
            state     <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if_done_q <= 1'b0;
          dm_done_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (LAT = 2)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_port_arbiter #(.AW(16), .DW(16), .LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory model: word at address a is a ^ 16'hA5B5 (0x0010 -> 0xA5A5)
  assign bus.mem_rdata = bus.mem_addr ^ 16'hA5B5;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0;

    // reset then idle
    rst_n = 0; step(); step(); rst_n = 1; step();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    chk("rst_done", {bus.if_done, bus.dm_done}, 0);
    chk("rst_busy_owner", {bus.busy, bus.owner}, 0);

    // IF read, request seen in cycle T
    bus.if_req = 1; bus.if_addr = 16'h0010;
    step();
    chk("ifrd_t1_en", 32'(bus.mem_en), 1);
    chk("ifrd_t1_addr", 32'(bus.mem_addr), 32'h0010);
    chk("ifrd_t1_we", 32'(bus.mem_we), 0);
    chk("ifrd_t1_busy", 32'(bus.busy), 1);
    chk("ifrd_t1_done", 32'(bus.if_done), 0);
    step();
    chk("ifrd_t2_en", 32'(bus.mem_en), 1);
    chk("ifrd_t2_done", 32'(bus.if_done), 0);
    step();
    chk("ifrd_t3_done", {bus.if_done, bus.dm_done}, 32'h2);
    chk("ifrd_t3_rdata", 32'(bus.if_rdata), 32'hA5A5);
    chk("ifrd_t3_en", 32'(bus.mem_en), 0);
    chk("ifrd_t3_owner", 32'(bus.owner), 0);
    bus.if_req = 0;
    step();
    chk("ifrd_t4_done", 32'(bus.if_done), 0);
    chk("ifrd_t4_busy", 32'(bus.busy), 0);

    // DM write
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 16'h0040; bus.dm_wdata = 16'h1234;
    step();
    chk("dmwr_t1_bus", {bus.mem_en, bus.mem_we, bus.mem_wdata}, 32'h3_1234);
    chk("dmwr_t1_owner", 32'(bus.owner), 1);
    step();
    chk("dmwr_t2_bus", {bus.mem_en, bus.mem_we, bus.mem_wdata}, 32'h3_1234);
    step();
    chk("dmwr_t3_done", {bus.if_done, bus.dm_done}, 32'h1);
    chk("dmwr_t3_rdata", 32'(bus.dm_rdata), 0);
    chk("dmwr_t3_we", {bus.mem_en, bus.mem_we}, 0);
    bus.dm_req = 0; bus.dm_we = 0;
    step();

    // DM read with address change and dropped req mid-access
    bus.dm_req = 1; bus.dm_addr = 16'h0020;
    step();
    bus.dm_addr = 16'h0099; bus.dm_req = 0;
    chk("dmrd_t1_addr", 32'(bus.mem_addr), 32'h0020);
    step();
    chk("dmrd_t2_addr", 32'(bus.mem_addr), 32'h0020);
    step();
    chk("dmrd_t3_done", 32'(bus.dm_done), 1);
    chk("dmrd_t3_rdata", 32'(bus.dm_rdata), 32'hA595);
    chk("dmrd_ifrdata_kept", 32'(bus.if_rdata), 32'hA5A5);
    step();
    chk("dmrd_t4_done", {bus.dm_done, bus.busy}, 0);
    step();
    chk("dmrd_t5_quiet", {bus.mem_en, bus.dm_done}, 0);

`ifndef ARB_RR_EN
    // tie: DM first, IF after dm_done (cycle D) is granted at D+1, done at D+4
    bus.if_req = 1; bus.if_addr = 16'h0010;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0030;
    step();
    chk("tie_first_owner", 32'(bus.owner), 1);
    chk("tie_first_addr", 32'(bus.mem_addr), 32'h0030);
    step(); step();
    chk("tie_dm_done", {bus.if_done, bus.dm_done}, 32'h1);
    chk("tie_dm_rdata", 32'(bus.dm_rdata), 32'hA585);
    bus.dm_req = 0;
    step();
    chk("tie_idle_gap", 32'(bus.busy), 0);
    step();
    chk("tie_second_owner", 32'(bus.owner), 0);
    chk("tie_second_addr", {bus.mem_en, bus.mem_addr}, 32'h1_0010);
    step();
    chk("tie_if_not_yet", 32'(bus.if_done), 0);
    step();
    chk("tie_if_done", {bus.if_done, bus.dm_done}, 32'h2);
    bus.if_req = 0;
    step();
`else
    // round-robin: fresh reset so last_owner = IF, then DM, IF, DM
    rst_n = 0; step(); rst_n = 1;
    bus.if_req = 1; bus.if_addr = 16'h0010;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0030;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("rr_owner", 32'(bus.owner), (g == 1) ? 0 : 1);
      step(); step();
      chk("rr_done", {bus.if_done, bus.dm_done}, (g == 1) ? 32'h2 : 32'h1);
      step();
      if (g == 2) begin
        bus.if_req = 0; bus.dm_req = 0;
      end
    end
    step();
`endif

    // reset during ACCESS aborts with no done pulse
    bus.if_req = 1; bus.if_addr = 16'h0050;
    step();
    chk("rstmid_en", 32'(bus.mem_en), 1);
    rst_n = 0; bus.if_req = 0;
    step();
    chk("rstmid_en_off", {bus.mem_en, bus.busy}, 0);
    chk("rstmid_done0", {bus.if_done, bus.dm_done}, 0);
    rst_n = 1;
    step();
    chk("rstmid_done1", {bus.if_done, bus.dm_done}, 0);
    step();
    chk("rstmid_done2", {bus.if_done, bus.dm_done, bus.busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between two requesters: the instruction-fetch stage (IF port) and the data-memory stage (DM port).
- Sits between the stage controller's IF/MEM datapath and the unified memory.
- Sequences each access as a multi-cycle transaction: grant, hold the memory bus for LAT cycles, capture read data, pulse done.
- Only one transaction is in flight at a time.

Parameters:
- AW, 16, address width
- DW, 16, data width
- LAT, 2, memory access cycles per transaction (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word, registered
- if_done  out  1  one-cycle completion pulse for the fetch port
- dm_req  in  1  data request; held high until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read data, registered
- dm_done  out  1  one-cycle completion pulse for the data port
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid during the last cycle of an access
- busy  out  1  high whenever state is not IDLE
- owner  out  1  owner of the current or last transaction: 0 = IF, 1 = DM

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE; count = 0. Every output goes to 0, including if_rdata, dm_rdata, mem_* and owner.
- Reset mid-transaction aborts it:
  - No done pulse is issued.
  - mem_en is 0 from the following cycle.
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - mem_en = 0.
  - If any req is high, select a winner (see arbitration).
  - Latch the winner's address into mem_addr. For DM, also latch dm_we into mem_we and dm_wdata into mem_wdata; for IF, mem_we = 0.
  - Set owner, set count = LAT-1, go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_addr, mem_we and mem_wdata are held stable.
  - count decrements each cycle.
  - When count = 0 (the last access cycle):
    - A read captures mem_rdata into if_rdata or dm_rdata, according to owner.
    - A write leaves dm_rdata unchanged.
    - Go to RESP.
- RESP:
  - mem_en = 0 and mem_we = 0.
  - The owner's done output is 1 for exactly this cycle.
  - Go to IDLE.
  - New requests are not sampled in RESP, so there is always at least one IDLE cycle between transactions.
- Latency: req first sampled high in IDLE at cycle T → mem_en high for cycles T+1 .. T+LAT → done high at cycle T+LAT+1.
- Arbitration when only one req is high: that requester wins.
- Arbitration when both are high: DM wins (fixed priority, because it serves the older instruction). Exception: see ARB_RR_EN.
- Requester inputs are sampled only in IDLE. Changes to addr, wdata, we or req during ACCESS or RESP are ignored.
- A req dropped mid-transaction does not cancel it: the transaction completes and done still pulses.
- A req still high in the IDLE cycle after its own done is treated as a new request.
- if_done and dm_done are never high in the same cycle.
- rdata outputs hold their last value until the next read for the same port.
- LAT = 1: ACCESS lasts a single cycle; capture and transition to RESP happen in that cycle.
- Counter width is 4 bits; LAT outside 1..15 is unsupported.

Optional Feature:
- Macro: ARB_RR_EN
- Defined:
  - A last_owner register (reset 0, i.e. IF) is updated on each grant.
  - When both req are high in IDLE, the requester that is not last_owner wins.
  - Single-request behaviour is unchanged.
- Undefined: fixed priority, DM wins every tie. No last_owner register exists.

Test Plan:
- Reset, then idle: rst_n = 0 for 2 cycles, then 1, with no req → every output 0; busy = 0; owner = 0.
- IF read, LAT = 2: if_req = 1 with if_addr = 0x0010 at T; memory returns 0xA5A5 → mem_en = 1 at T+1 and T+2 with mem_addr = 0x0010 and mem_we = 0; if_done = 1 only at T+3; if_rdata = 0xA5A5; owner = 0.
- DM write: dm_req = 1, dm_we = 1, dm_addr = 0x0040, dm_wdata = 0x1234 at T → mem_we = 1 and mem_wdata = 0x1234 for LAT cycles; dm_done at T+LAT+1; dm_rdata unchanged.
- Simultaneous requests, both held (macro undefined) → DM served first; IF granted in the IDLE cycle after dm_done; if_done at (dm_done cycle)+LAT+2.
- With ARB_RR_EN, three back-to-back ties with both reqs held → grant order DM, IF, DM.
- Mid-transaction events:
  - Input changes: change dm_addr to 0x0099 during ACCESS → mem_addr stays at the latched value.
  - Dropped request: drop dm_req during ACCESS → dm_done still pulses once.
  - Reset: assert rst_n = 0 during ACCESS → no done pulse; mem_en = 0 the next cycle; busy = 0.
